// File: rtl/gerenciador_atributos.sv
// Pet vital attributes (fome, felicidade, sono): prescaled decay plus activity-driven recovery.
// Optional low-attribute flags on port alerta are built only when ATRIBUTOS_ALERTA_EN is defined.
module gerenciador_atributos #(
    parameter int TICK_DIV      = 50000,
    parameter int VALOR_INICIAL = 200,
    parameter int DECAIMENTO    = 1,
    parameter int GANHO         = 8
`ifdef ATRIBUTOS_ALERTA_EN
    ,
    parameter int LIMIAR_ALERTA = 32
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] estado,
    output logic [7:0] fome,
    output logic [7:0] felicidade,
    output logic [7:0] sono,
    output logic       tick
`ifdef ATRIBUTOS_ALERTA_EN
    ,
    output logic [2:0] alerta
`endif
);

    localparam int         CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
    localparam logic [7:0] VAL_INI   = 8'(VALOR_INICIAL);
    localparam logic [8:0] DEC_1     = 9'(DECAIMENTO);
    localparam logic [8:0] DEC_2     = 9'(2 * DECAIMENTO);
    localparam logic [8:0] GAN       = 9'(GANHO);

    localparam logic [3:0] ST_DORMINDO   = 4'b0001;
    localparam logic [3:0] ST_COMENDO    = 4'b0010;
    localparam logic [3:0] ST_DANDO_AULA = 4'b0100;
    localparam logic [3:0] ST_MORTO      = 4'b1000;

    // Subtract with a floor at 0 so a starved attribute never wraps to 255.
    function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [8:0] d);
        logic [8:0] r;
        r = {1'b0, a} - d;
        return (d > {1'b0, a}) ? 8'd0 : r[7:0];
    endfunction

    // Add with a ceiling at 255 so a full attribute never wraps to 0.
    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [8:0] g);
        logic [9:0] r;
        r = {2'b00, a} + {1'b0, g};
        return (r > 10'd255) ? 8'hFF : r[7:0];
    endfunction

    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    fome_q, fome_d;
    logic [7:0]    fel_q, fel_d;
    logic [7:0]    sono_q, sono_d;
    logic          tick_q, tick_d;
    logic          wrap_s;

    assign wrap_s = (cnt_q == CNT_MAX);

    // Prescaler and attribute next-state; attributes only move on the wrap edge.
    always_comb begin
        cnt_d  = wrap_s ? {CW{1'b0}} : cnt_q + CW'(1);
        tick_d = wrap_s;
        fome_d = fome_q;
        fel_d  = fel_q;
        sono_d = sono_q;
        if (wrap_s) begin
            case (estado)
                ST_MORTO: begin
                    fome_d = fome_q;
                    fel_d  = fel_q;
                    sono_d = sono_q;
                end
                ST_COMENDO: begin
                    fome_d = sat_add(fome_q, GAN);
                    fel_d  = sat_sub(fel_q, DEC_1);
                    sono_d = sat_sub(sono_q, DEC_1);
                end
                ST_DORMINDO: begin
                    fome_d = sat_sub(fome_q, DEC_1);
                    fel_d  = sat_sub(fel_q, DEC_1);
                    sono_d = sat_add(sono_q, GAN);
                end
                ST_DANDO_AULA: begin
                    fome_d = sat_sub(fome_q, DEC_2);
                    fel_d  = sat_add(fel_q, GAN);
                    sono_d = sat_sub(sono_q, DEC_2);
                end
                // IDLE and every invalid or multi-hot code decay uniformly
                default: begin
                    fome_d = sat_sub(fome_q, DEC_1);
                    fel_d  = sat_sub(fel_q, DEC_1);
                    sono_d = sat_sub(sono_q, DEC_1);
                end
            endcase
        end else begin
            fome_d = fome_q;
            fel_d  = fel_q;
            sono_d = sono_q;
        end
    end

    // State registers for prescaler, attributes and the tick pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= {CW{1'b0}};
            fome_q <= VAL_INI;
            fel_q  <= VAL_INI;
            sono_q <= VAL_INI;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            fome_q <= fome_d;
            fel_q  <= fel_d;
            sono_q <= sono_d;
            tick_q <= tick_d;
        end
    end

    assign fome       = fome_q;
    assign felicidade = fel_q;
    assign sono       = sono_q;
    assign tick       = tick_q;

`ifdef ATRIBUTOS_ALERTA_EN
    localparam logic [8:0] LIM = 9'(LIMIAR_ALERTA);

    logic [2:0] alerta_q, alerta_d;

    // Flags follow the freshly computed attributes so they change on the same edge.
    always_comb begin
        alerta_d = alerta_q;
        if (estado == ST_MORTO) begin
            alerta_d = 3'b000;
        end else if (wrap_s) begin
            alerta_d = {({1'b0, sono_d} < LIM), ({1'b0, fel_d} < LIM), ({1'b0, fome_d} < LIM)};
        end else begin
            alerta_d = alerta_q;
        end
    end

    // Alert flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alerta_q <= 3'b000;
        end else begin
            alerta_q <= alerta_d;
        end
    end

    assign alerta = alerta_q;
`endif

endmodule

// File: tb/tb_gerenciador_atributos.sv
// Directed bench for gerenciador_atributos with TICK_DIV=4, VALOR_INICIAL=200.
// Alert checks are compiled in when ATRIBUTOS_ALERTA_EN is defined.
module tb_gerenciador_atributos;

    localparam logic [3:0] IDLE  = 4'b0000;
    localparam logic [3:0] DORM  = 4'b0001;
    localparam logic [3:0] COME  = 4'b0010;
    localparam logic [3:0] AULA  = 4'b0100;
    localparam logic [3:0] MORTO = 4'b1000;

    logic       clk;
    logic       rst_n;
    logic [3:0] estado;
    logic [7:0] fome;
    logic [7:0] felicidade;
    logic [7:0] sono;
    logic       tick;
`ifdef ATRIBUTOS_ALERTA_EN
    logic [2:0] alerta;
`endif

    int n_checks;
    int n_pass;
    int steps;

    gerenciador_atributos #(
        .TICK_DIV(4),
        .VALOR_INICIAL(200),
        .DECAIMENTO(1),
        .GANHO(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .estado(estado),
        .fome(fome),
        .felicidade(felicidade),
        .sono(sono),
        .tick(tick)
`ifdef ATRIBUTOS_ALERTA_EN
        ,
        .alerta(alerta)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_vals(input string tag, input int f, input int fe, input int s);
        check({tag, ".fome"}, {24'd0, fome}, f);
        check({tag, ".felicidade"}, {24'd0, felicidade}, fe);
        check({tag, ".sono"}, {24'd0, sono}, s);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Advance to the negedge right after the next update edge; bounded.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick && n < 8);
        check("tick_seen", {31'd0, tick}, 32'd1);
    endtask

    task automatic run_ticks(input logic [3:0] st, input int n);
        int s;
        estado = st;
        for (int i = 0; i < n; i++) wait_tick(s);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        estado   = IDLE;
        repeat (3) @(negedge clk);
        check_vals("reset", 200, 200, 200);
        check("reset.tick", {31'd0, tick}, 32'd0);
`ifdef ATRIBUTOS_ALERTA_EN
        check("reset.alerta", {29'd0, alerta}, 32'd0);
`endif

        // Release, three quiet edges, update on the fourth.
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check_vals("decay.pre", 200, 200, 200);
            check("decay.pre_tick", {31'd0, tick}, 32'd0);
        end
        step();
        check_vals("decay.first", 199, 199, 199);
        check("decay.tick_hi", {31'd0, tick}, 32'd1);
        step();
        check("decay.tick_lo", {31'd0, tick}, 32'd0);

        // Eating with saturation at 255.
        run_ticks(IDLE, 5);
        check_vals("idle5", 194, 194, 194);
        run_ticks(COME, 7);
        check_vals("eat7", 250, 187, 187);
        run_ticks(COME, 1);
        check_vals("eat_sat", 255, 186, 186);
        run_ticks(COME, 1);
        check_vals("eat_sat2", 255, 185, 185);

        // Asynchronous reset with prescaler at 2.
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        check_vals("midrst", 200, 200, 200);
        check("midrst.tick", {31'd0, tick}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        estado = MORTO;
        rst_n  = 1'b1;
        wait_tick(steps);
        check("midrst.latency", steps, 32'd4);
        check_vals("midrst.morto", 200, 200, 200);

        // Teaching: double decay with floor at 0.
        run_ticks(AULA, 1);
        check_vals("aula1", 198, 208, 198);
        run_ticks(AULA, 99);
        check_vals("aula100", 0, 255, 0);
        run_ticks(DORM, 2);
        check_vals("dorm2", 0, 253, 16);
        run_ticks(COME, 2);
        check_vals("come2", 16, 251, 14);
        run_ticks(IDLE, 13);
        check_vals("setup31", 3, 238, 1);
        run_ticks(AULA, 1);
        check_vals("aula_floor", 1, 246, 0);
        run_ticks(AULA, 1);
        check_vals("aula_floor2", 0, 254, 0);

        // Death freeze: values hold, tick keeps its period.
        run_ticks(DORM, 12);
        run_ticks(IDLE, 6);
        check_vals("pre_morto", 0, 236, 90);
        estado = MORTO;
        for (int i = 0; i < 10; i++) begin
            wait_tick(steps);
            check("morto.period", steps, 32'd4);
            check_vals("morto", 0, 236, 90);
        end

        // Invalid encodings behave as IDLE.
        run_ticks(4'b0110, 1);
        check_vals("inv0110", 0, 235, 89);
        run_ticks(4'b1111, 1);
        check_vals("inv1111", 0, 234, 88);
        run_ticks(4'b0011, 1);
        check_vals("inv0011", 0, 233, 87);

        // Threshold crossing of sono.
        run_ticks(IDLE, 54);
        check_vals("sono33", 0, 179, 33);
`ifdef ATRIBUTOS_ALERTA_EN
        check("alerta33", {29'd0, alerta}, 32'd1);
`endif
        run_ticks(IDLE, 1);
        check_vals("sono32", 0, 178, 32);
`ifdef ATRIBUTOS_ALERTA_EN
        check("alerta32", {29'd0, alerta}, 32'd1);
`endif
        run_ticks(IDLE, 1);
        check_vals("sono31", 0, 177, 31);
`ifdef ATRIBUTOS_ALERTA_EN
        check("alerta31", {29'd0, alerta}, 32'd5);
`endif
        estado = MORTO;
        step();
        check_vals("final_morto", 0, 177, 31);
`ifdef ATRIBUTOS_ALERTA_EN
        check("alerta_morto", {29'd0, alerta}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gerenciador_atributos.md
Name: gerenciador_atributos

Overview:
- Produces the pet's three 8-bit vital attributes: fome (satiety), felicidade (happiness) and sono (rest).
- Consumes the 4-bit one-hot estado from the state controller and closes the loop back to it; that controller declares death when any attribute reaches 0.
- Attributes decay on a slow prescaled tick and recover according to the current activity.
- Sits beside the state controller in the top level and feeds the display/LED logic.

Parameters:
- TICK_DIV, 50000, clk cycles per attribute tick (minimum 2)
- VALOR_INICIAL, 200, reset value of every attribute (0..255)
- DECAIMENTO, 1, per-tick decrement of a decaying attribute
- GANHO, 8, per-tick increment of the attribute being restored
- LIMIAR_ALERTA, 32, low-attribute threshold (optional feature only)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- estado  in  4  one-hot: IDLE=0000, DORMINDO=0001, COMENDO=0010, DANDO_AULA=0100, MORTO=1000
- fome  out  8  satiety, 0 = starved
- felicidade  out  8  happiness, 0 = depressed
- sono  out  8  rest, 0 = exhausted
- tick  out  1  registered one-cycle pulse marking an attribute update
- alerta  out  3  {sono,felicidade,fome} low flags (present only with the optional feature)

Behaviour:
- Reset (rst_n=0, asynchronous) sets:
  - fome, felicidade, sono = VALOR_INICIAL
  - prescaler = 0, tick = 0
  - alerta = 0 (optional feature only)
- Release of reset is synchronous to clk.
- Prescaler counts 0..TICK_DIV-1 and wraps to 0.
- The wrap edge is the update edge:
  - all three attributes are updated from the estado value sampled at that edge;
  - tick is 1 for exactly the following cycle and 0 otherwise.
- Outputs are registered. There is 0-cycle latency from the update edge, and at most TICK_DIV cycles from an estado change to its first effect.
- Per update, by estado:
  - IDLE: all three -= DECAIMENTO.
  - COMENDO: fome += GANHO; felicidade and sono -= DECAIMENTO.
  - DORMINDO: sono += GANHO; fome and felicidade -= DECAIMENTO.
  - DANDO_AULA: felicidade += GANHO; fome and sono -= 2*DECAIMENTO.
  - MORTO: all attributes frozen; prescaler keeps running; tick still pulses.
  - Any other encoding (multi-hot or invalid): treated as IDLE.
- Arithmetic uses 9-bit intermediates and saturates:
  - decrement floors at 0 and never wraps to 255;
  - increment caps at 255 and never wraps to 0.
  - Example: 3 - 2*1 = 1; 1 - 2 = 0; 250 + 8 = 255.
- An attribute at 0 stays 0 under decay, so death is stable even before estado becomes MORTO.
- Mid-operation reset: values return to VALOR_INICIAL immediately and the prescaler restarts. The first update after release occurs TICK_DIV cycles after the first clk edge with rst_n=1.
- estado changing on the update edge itself: the value sampled at that edge is used.

Optional Feature:
- Macro: ATRIBUTOS_ALERTA_EN.
- When defined:
  - port alerta[2:0] exists;
  - bit i is registered 1 when the corresponding attribute < LIMIAR_ALERTA, and is updated on the same edge as the attribute;
  - bit0=fome, bit1=felicidade, bit2=sono;
  - reset value 0; forced to 000 while estado=MORTO.
- When undefined: alerta port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, decay: TICK_DIV=4, VALOR_INICIAL=200, estado=IDLE, release reset -> all three =200 with tick=0 for 3 cycles; at the 4th edge all =199 and tick=1 for 1 cycle.
- Eating, saturation: estado=COMENDO from fome=250 -> after 1 tick fome=255, felicidade=sono=199; after another tick fome stays 255.
- Teaching: estado=DANDO_AULA, fome=3, sono=1 -> after 1 tick fome=1, sono=0, felicidade+8; after next tick fome=0, sono=0, no wrap.
- Death freeze: estado=MORTO with fome=0, felicidade=40, sono=90 for 10 ticks -> values unchanged, tick still pulsing every 4 cycles.
- Reset mid-run: assert rst_n=0 asynchronously between edges while prescaler=2 -> outputs =200 immediately, tick=0; next update exactly 4 edges after release.
- Alerta (ATRIBUTOS_ALERTA_EN, LIMIAR_ALERTA=32): sono 33 -> 32 -> 31 in IDLE -> alerta[2]=0, 0, then 1 on the update edge that produces 31; estado=MORTO -> alerta=000.
